lockstep_compare_monitor: RTL

//  Parametrised, synthesizable lockstep checker for golden-vs-post-route equivalence benches.
//  Two instances of a design are driven with the same stimulus; this block compares their output buses.
//  - Compares a golden bus against a DUT bus per channel, under a bit mask, on a programmable sample cadence.
//  - Counts compares and mismatches.
//  - Captures the first failure and reports pass/fail when the run stops.
//  - Replaces ad-hoc per-bench compare tasks; reusable in sim benches and on-chip self-test.

---
 rtl/lockstep_pkg.sv | 21 ++
 rtl/lockstep_lane_cmp.sv | 23 ++
 rtl/lockstep_compare_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep compare monitor.
package lockstep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} lk_state_t;

  // Widest counter sat_inc can handle.
  localparam int unsigned LK_SAT_MAX_W = 32;

  // Width of the channel-index field: one bit more than needed to address NUM_CH.
  function automatic int unsigned lk_ch_w(input int unsigned num_ch);
    return $clog2(num_ch) + 1;
  endfunction

  // Saturating increment of a w-bit counter, held in a 32-bit container.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= LK_SAT_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lockstep_lane_cmp.sv
// One channel of the lockstep compare: masked golden-vs-dut difference.
module lockstep_lane_cmp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned XCHK  = 1
) (
  input  logic [WIDTH-1:0] golden_i,
  input  logic [WIDTH-1:0] dut_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             fail_o
);

  logic [WIDTH-1:0] diff;

  assign diff = (golden_i ^ dut_i) & mask_i;

  if (XCHK != 0) begin : g_xchk
    // An unknown on any checked bit of either bus poisons the reduction.
    assign fail_o = (|diff) || ((^{golden_i & mask_i, dut_i & mask_i}) === 1'bx);
  end else begin : g_plain
    assign fail_o = |diff;
  end

endmodule

// File: rtl/lockstep_compare_monitor.sv
// Lockstep checker: samples golden vs dut buses per channel on a fixed cadence,
// counts compares and mismatches, and captures the first failure of each run.
module lockstep_compare_monitor
  import lockstep_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned SAMPLE_DIV = 2,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned XCHK       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [NUM_CH*WIDTH-1:0]   golden,
  input  logic [NUM_CH*WIDTH-1:0]   dut,
  input  logic [NUM_CH*WIDTH-1:0]   mask,
  output logic                      busy,
  output logic                      mismatch,
  output logic [CNT_W-1:0]          compare_cnt,
  output logic [CNT_W-1:0]          mismatch_cnt,
  output logic                      first_vld,
  output logic [$clog2(NUM_CH):0]   first_ch,
  output logic [WIDTH-1:0]          first_gold,
  output logic [WIDTH-1:0]          first_dut,
  output logic [CNT_W-1:0]          first_stamp,
  output logic                      done,
  output logic                      pass
);

  localparam int unsigned CH_W = lk_ch_w(NUM_CH);
  localparam int unsigned PH_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  lk_state_t         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [CNT_W-1:0]  mm_q, mm_d;
  logic              pulse_q, pulse_d;
  logic              fvld_q, fvld_d;
  logic [CH_W-1:0]   fch_q, fch_d;
  logic [WIDTH-1:0]  fgold_q, fgold_d;
  logic [WIDTH-1:0]  fdut_q, fdut_d;
  logic [CNT_W-1:0]  fstamp_q, fstamp_d;

  logic [NUM_CH-1:0] fail;
  logic              sample;
  logic              phase_last;
  logic [CH_W-1:0]   sel_ch;
  logic [WIDTH-1:0]  sel_gold;
  logic [WIDTH-1:0]  sel_dut;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    lockstep_lane_cmp #(
      .WIDTH (WIDTH),
      .XCHK  (XCHK)
    ) u_lane (
      .golden_i (golden[c*WIDTH +: WIDTH]),
      .dut_i    (dut[c*WIDTH +: WIDTH]),
      .mask_i   (mask[c*WIDTH +: WIDTH]),
      .fail_o   (fail[c])
    );
  end

  assign phase_last = (phase_q == PH_W'(SAMPLE_DIV - 1));
  assign sample     = (state_q == RUN) && phase_last;

  // Priority encoder: lowest failing channel and its bus values.
  always_comb begin
    sel_ch   = '0;
    sel_gold = '0;
    sel_dut  = '0;
    // Scan downwards so the lowest failing index is the last one written.
    for (int unsigned c = NUM_CH; c > 0; c--) begin
      if (fail[c-1]) begin
        sel_ch   = CH_W'(c - 1);
        sel_gold = golden[(c-1)*WIDTH +: WIDTH];
        sel_dut  = dut[(c-1)*WIDTH +: WIDTH];
      end
    end
  end

  // Run control, sampling cadence, counters and first-failure capture.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    cmp_d    = cmp_q;
    mm_d     = mm_q;
    pulse_d  = 1'b0;
    fvld_d   = fvld_q;
    fch_d    = fch_q;
    fgold_d  = fgold_q;
    fdut_d   = fdut_q;
    fstamp_d = fstamp_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = (SETTLE_CYC == 0) ? RUN : SETTLE;
          phase_d  = '0;
          settle_d = '0;
          cmp_d    = '0;
          mm_d     = '0;
          fvld_d   = 1'b0;
          fch_d    = '0;
          fgold_d  = '0;
          fdut_d   = '0;
          fstamp_d = '0;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_d = DONE;
        end else if (settle_q == ST_W'(SETTLE_CYC - 1)) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end
      RUN: begin
        phase_d = phase_last ? '0 : phase_q + PH_W'(1);
        if (sample) begin
          cmp_d = CNT_W'(sat_inc(32'(cmp_q), CNT_W));
          if (|fail) begin
            mm_d    = CNT_W'(sat_inc(32'(mm_q), CNT_W));
            pulse_d = 1'b1;
            if (!fvld_q) begin
              fvld_d   = 1'b1;
              fch_d    = sel_ch;
              fgold_d  = sel_gold;
              fdut_d   = sel_dut;
              fstamp_d = cmp_q;
            end
          end
        end
        if (stop) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      settle_q <= '0;
      cmp_q    <= '0;
      mm_q     <= '0;
      pulse_q  <= 1'b0;
      fvld_q   <= 1'b0;
      fch_q    <= '0;
      fgold_q  <= '0;
      fdut_q   <= '0;
      fstamp_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      settle_q <= settle_d;
      cmp_q    <= cmp_d;
      mm_q     <= mm_d;
      pulse_q  <= pulse_d;
      fvld_q   <= fvld_d;
      fch_q    <= fch_d;
      fgold_q  <= fgold_d;
      fdut_q   <= fdut_d;
      fstamp_q <= fstamp_d;
    end
  end

  assign busy         = (state_q == SETTLE) || (state_q == RUN);
  assign done         = (state_q == DONE);
  assign pass         = done && (|cmp_q) && !(|mm_q);
  assign mismatch     = pulse_q;
  assign compare_cnt  = cmp_q;
  assign mismatch_cnt = mm_q;
  assign first_vld    = fvld_q;
  assign first_ch     = fch_q;
  assign first_gold   = fgold_q;
  assign first_dut    = fdut_q;
  assign first_stamp  = fstamp_q;

endmodule
